// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, sequencer state encoding and per-op latency lookup
// for the sequenced ALU control decoder.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_LD_ADD  = 4'b0001;
  localparam logic [3:0] ALU_BR_SUB  = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_MUL     = 4'b0101;
  localparam logic [3:0] ALU_DIV     = 4'b0110;
  localparam logic [3:0] ALU_OR      = 4'b0111;
  localparam logic [3:0] ALU_AND     = 4'b1000;
  localparam logic [3:0] ALU_XOR     = 4'b1001;
  localparam logic [3:0] ALU_SLL     = 4'b1010;
  localparam logic [3:0] ALU_SRL     = 4'b1011;
  localparam logic [3:0] ALU_SLT     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Illegal codes fall through to a single cycle so the pipeline drains.
  function automatic int op_latency(input logic [3:0] code, input int mul_lat, input int div_lat);
    if (code == ALU_MUL) return mul_lat;
    if (code == ALU_DIV) return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_ctrl_lut.sv
// Combinational {ALU_Op, funct} decode into a 4-bit ALU control code plus
// illegal and multi-cycle flags.
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 5,
  parameter int ALUOP_W = 2
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         code,
  output logic               illegal,
  output logic               multi
);

  logic upper_zero;

  // Shift instead of slicing so ALUOP_W == 2 needs no special case.
  assign upper_zero = ((alu_op >> 2) == '0);

  always_comb begin
    // NOTE: default assignment first so every path drives code; no latch is inferred.
    code = ALU_ILLEGAL;
    if (!upper_zero) begin
      code = ALU_ILLEGAL;
    end else if (alu_op[1:0] == 2'b00) begin
      code = ALU_LD_ADD;
    end else if (alu_op[0]) begin
      code = ALU_BR_SUB;
    end else begin
      // Full-width compares: upper funct bits must be zero for a legal R-type op.
      case (funct)
        FUNCT_W'(0): code = ALU_ADD;
        FUNCT_W'(1): code = ALU_SUB;
        FUNCT_W'(2): code = ALU_MUL;
        FUNCT_W'(3): code = ALU_DIV;
        FUNCT_W'(4): code = ALU_OR;
        FUNCT_W'(5): code = ALU_AND;
        FUNCT_W'(6): code = ALU_XOR;
        FUNCT_W'(7): code = ALU_SLL;
        FUNCT_W'(8): code = ALU_SRL;
        FUNCT_W'(9): code = ALU_SLT;
        default:     code = ALU_ILLEGAL;
      endcase
    end
  end

  assign illegal = (code == ALU_ILLEGAL);
  assign multi   = (code == ALU_MUL) || (code == ALU_DIV);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control decoder: accepts one request per handshake, holds
// multiply/divide for their latency, presents the code on a valid/ready output.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 5,
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Flush,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] ALU_Op,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [CTRL_W-1:0]  ALU_Control,
  output logic               Multi_Cycle,
  output logic               Illegal,
  output logic               Busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              multi_q, multi_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        lut_code;
  logic              lut_illegal;
  logic              lut_multi;
  logic              accept;
  int                lat;

  alu_ctrl_lut #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_lut (
    .alu_op  (ALU_Op),
    .funct   (funct),
    .code    (lut_code),
    .illegal (lut_illegal),
    .multi   (lut_multi)
  );

  assign lat = op_latency(lut_code, MUL_LAT, DIV_LAT);

  // Flush blocks acceptance so an aborted cycle can never load a new op.
  assign In_Ready  = !Flush && ((state_q == IDLE) || ((state_q == HOLD) && Out_Ready));
  assign accept    = In_Valid && In_Ready;
  assign Out_Valid = (state_q == HOLD);
  assign Busy      = (state_q != IDLE);

  assign ALU_Control = ctrl_q;
  assign Multi_Cycle = multi_q;
  assign Illegal     = illegal_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    multi_d   = multi_q;
    illegal_d = illegal_q;

    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      ctrl_d    = CTRL_W'(lut_code);
      multi_d   = lut_multi;
      illegal_d = lut_illegal;
      cnt_d     = CNT_W'(lat - 1);
      state_d   = (lat == 1) ? HOLD : EXEC;
    end else begin
      case (state_q)
        EXEC: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = HOLD;
        end
        HOLD: begin
          if (Out_Ready) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      multi_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      multi_q   <= multi_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus random op
// streams compared against a transaction-level decode/latency model.
module tb_alu_ctrl_seq;

  localparam int FUNCT_W = 5;
  localparam int ALUOP_W = 2;
  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               Flush;
  logic               In_Valid;
  logic               In_Ready;
  logic [FUNCT_W-1:0] funct;
  logic [ALUOP_W-1:0] ALU_Op;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [CTRL_W-1:0]  ALU_Control;
  logic               Multi_Cycle;
  logic               Illegal;
  logic               Busy;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_code;
  int         exp_lat;
  logic       exp_ill;
  logic       exp_multi;

  alu_ctrl_seq #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W),
    .CTRL_W  (CTRL_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .funct       (funct),
    .ALU_Op      (ALU_Op),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .ALU_Control (ALU_Control),
    .Multi_Cycle (Multi_Cycle),
    .Illegal     (Illegal),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference decode: R-type codes are funct + 3 for funct 0..9.
  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [4:0] f);
    if (op == 2'b00) return 4'd1;
    if (op[0])       return 4'd2;
    if (f < 5'd10)   return 4'(f + 5'd3);
    return 4'd15;
  endfunction

  task automatic set_exp(input logic [1:0] op, input logic [4:0] f);
    exp_code  = ref_code(op, f);
    exp_lat   = (exp_code == 4'd5) ? MUL_LAT : (exp_code == 4'd6) ? DIV_LAT : 1;
    exp_ill   = (exp_code == 4'd15);
    exp_multi = (exp_code == 4'd5) || (exp_code == 4'd6);
  endtask

  function automatic logic [1:0] rand_op();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [4:0] rand_f();
    if ($urandom_range(0, 2) == 0) return 5'($urandom_range(2, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] f, input logic out_rdy);
    ALU_Op    = op;
    funct     = f;
    In_Valid  = 1'b1;
    Out_Ready = out_rdy;
    set_exp(op, f);
    @(negedge clk);
    check_bit("accept_in_ready", In_Ready, 1'b1);
    @(posedge clk); #1;
    In_Valid = 1'b0;
  endtask

  // Follows the op accepted on the previous edge through EXEC and HOLD.
  // With chain set, a new request is offered in the cycle Out_Ready rises.
  task automatic await(input int stall, input logic chain, input logic [1:0] cop, input logic [4:0] cf);
    for (int n = 1; n < exp_lat; n++) begin
      @(negedge clk);
      check_bit("exec_out_valid", Out_Valid, 1'b0);
      check_bit("exec_in_ready", In_Ready, 1'b0);
      check_bit("exec_busy", Busy, 1'b1);
      check("exec_ctrl", ALU_Control, exp_code);
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      Out_Ready = (s == stall);
      if (s == stall && chain) begin
        ALU_Op   = cop;
        funct    = cf;
        In_Valid = 1'b1;
      end
      @(negedge clk);
      check_bit("hold_out_valid", Out_Valid, 1'b1);
      check("hold_ctrl", ALU_Control, exp_code);
      check_bit("hold_illegal", Illegal, exp_ill);
      check_bit("hold_multi", Multi_Cycle, exp_multi);
      check_bit("hold_in_ready", In_Ready, s == stall);
      @(posedge clk); #1;
    end
    In_Valid = 1'b0;
    if (chain) begin
      set_exp(cop, cf);
    end else begin
      @(negedge clk);
      check_bit("idle_out_valid", Out_Valid, 1'b0);
      check_bit("idle_busy", Busy, 1'b0);
      check_bit("idle_in_ready", In_Ready, 1'b1);
      check("idle_ctrl_kept", ALU_Control, exp_code);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    funct     = '0;
    ALU_Op    = '0;

    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_out_valid", Out_Valid, 1'b0);
    check("rst_ctrl", ALU_Control, 4'd0);
    check_bit("rst_multi", Multi_Cycle, 1'b0);
    check_bit("rst_illegal", Illegal, 1'b0);
    check_bit("rst_busy", Busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_bit("post_rst_in_ready", In_Ready, 1'b1);
    @(posedge clk); #1;

    // Load/store add, single cycle.
    issue(2'b00, 5'b10110, 1'b1);
    await(0, 1'b0, 2'b00, 5'd0);

    // Multiply.
    issue(2'b10, 5'b00010, 1'b1);
    await(0, 1'b0, 2'b00, 5'd0);

    // Divide held 4 extra cycles; new branch-sub accepted as Out_Ready rises.
    issue(2'b10, 5'b00011, 1'b1);
    await(4, 1'b1, 2'b01, 5'b00000);
    await(0, 1'b0, 2'b00, 5'd0);

    // Back-to-back sub then slt with no bubble.
    issue(2'b01, 5'b00000, 1'b1);
    await(0, 1'b1, 2'b10, 5'b01001);
    await(0, 1'b0, 2'b00, 5'd0);

    // Illegal funct completes in one cycle.
    issue(2'b10, 5'b01111, 1'b1);
    await(0, 1'b0, 2'b00, 5'd0);

    // Flush two cycles into a divide: no result, no accept during Flush.
    issue(2'b10, 5'b00011, 1'b1);
    @(negedge clk);
    check_bit("flush_pre_busy", Busy, 1'b1);
    @(posedge clk); #1;
    Flush    = 1'b1;
    In_Valid = 1'b1;
    ALU_Op   = 2'b00;
    funct    = 5'd0;
    @(negedge clk);
    check_bit("flush_in_ready", In_Ready, 1'b0);
    @(posedge clk); #1;
    Flush    = 1'b0;
    In_Valid = 1'b0;
    @(negedge clk);
    check_bit("flush_out_valid", Out_Valid, 1'b0);
    check_bit("flush_busy", Busy, 1'b0);
    check_bit("flush_in_ready_after", In_Ready, 1'b1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | Out_Valid;
    end
    check_bit("flush_no_result", seen, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset mid-HOLD clears everything at once.
    issue(2'b01, 5'd0, 1'b0);
    @(negedge clk);
    check_bit("pre_rst_hold", Out_Valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("async_rst_out_valid", Out_Valid, 1'b0);
    check("async_rst_ctrl", ALU_Control, 4'd0);
    check_bit("async_rst_multi", Multi_Cycle, 1'b0);
    check_bit("async_rst_illegal", Illegal, 1'b0);
    check_bit("async_rst_busy", Busy, 1'b0);
    @(posedge clk); #1;
    rst       = 1'b0;
    Out_Ready = 1'b1;
    @(negedge clk);
    check_bit("rerst_in_ready", In_Ready, 1'b1);
    @(posedge clk); #1;

    // Random op streams, random stalls and chained requests.
    for (int t = 0; t < 15; t++) begin
      int k;
      issue(rand_op(), rand_f(), 1'b1);
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) await($urandom_range(0, 2), 1'b1, rand_op(), rand_f());
      await($urandom_range(0, 2), 1'b0, 2'b00, 5'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised, sequenced successor to the combinational ALU decoder. Accepts one {ALU_Op, funct} request per valid/ready handshake and decodes it into a registered ALU_Control code. Tracks per-operation latency: multiply and divide hold the result path for MUL_LAT/DIV_LAT cycles. Sits between the main control unit and the ALU/datapath stall logic, and presents results on a valid/ready output.

Parameters:
- FUNCT_W, 5, width of funct field (≥4)
- ALUOP_W, 2, width of ALU_Op (≥2; only bits [1:0] are decoded, upper bits must be 0 or the request is illegal)
- CTRL_W, 4, width of ALU_Control (≥4; codes are zero-extended)
- MUL_LAT, 3, cycles from accept to Out_Valid for multiply (≥1)
- DIV_LAT, 8, cycles from accept to Out_Valid for divide (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous abort of the in-flight op
- In_Valid  in  1  request valid
- In_Ready  out  1  request accepted when In_Valid && In_Ready
- funct  in  FUNCT_W  function field
- ALU_Op  in  ALUOP_W  ALU operation class
- Out_Valid  out  1  decoded result valid
- Out_Ready  in  1  consumer accepts result
- ALU_Control  out  CTRL_W  decoded ALU control code
- Multi_Cycle  out  1  the current op is multiply or divide
- Illegal  out  1  the current op is undecodable (ALU_Control = 1111)
- Busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, cnt 0, ALU_Control 0, Multi_Cycle 0, Illegal 0, Out_Valid 0. In_Ready is 1 on the first cycle after release.
- Decode priority (first match wins):
  - ALU_Op=00 → 0001 (add)
  - ALU_Op[0]=1 → 0010 (sub)
  - ALU_Op=10 with funct 0..9 → 0011 add, 0100 sub, 0101 mul, 0110 div, 0111 or, 1000 and, 1001 xor, 1010 sll, 1011 srl, 1100 slt
  - Anything else (including funct ≥10 or nonzero upper ALU_Op bits) → 1111, Illegal=1
- Latency: lat = MUL_LAT for code 0101, DIV_LAT for 0110, otherwise 1.
- States:
  - IDLE: In_Ready=1, Out_Valid=0.
  - EXEC: counting down, In_Ready=0, Out_Valid=0.
  - HOLD: Out_Valid=1, In_Ready=Out_Ready.
- Accept (In_Valid && In_Ready): ALU_Control, Multi_Cycle and Illegal are registered; cnt <= lat-1; next state is HOLD if lat==1, else EXEC.
- EXEC: cnt decrements each cycle; when cnt==1, next state is HOLD. Out_Valid first appears exactly lat cycles after the accept cycle.
- HOLD:
  - Out_Ready=1 and new accept: back-to-back; load the new op (zero-bubble for single-cycle ops).
  - Out_Ready=1, no accept: return to IDLE.
  - Out_Ready=0: stay in HOLD; ALU_Control, Multi_Cycle and Illegal stay stable.
- Registered outputs are stable throughout EXEC and HOLD, and retain their last value in IDLE.
- Flush has priority over everything: next state IDLE, Out_Valid=0 next cycle, cnt=0, no accept that cycle (In_Ready forced 0 while Flush=1).
- Illegal ops still complete with lat=1 so the pipeline drains; the consumer handles the trap.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1). No wrap is possible, since cnt is only loaded on accept.
- rst asserted mid-EXEC or mid-HOLD: immediate return to reset values; the op is lost.
- No X propagation: unused funct bits are compared explicitly, with no casex wildcards.

Decomposition:
- Package alu_ctrl_pkg:
  - localparam codes ALU_ADD..ALU_SLT and ALU_ILLEGAL (4'b1111)
  - typedef enum state_t {IDLE, EXEC, HOLD}
  - function op_latency(code, MUL_LAT, DIV_LAT)
- Sub-module alu_ctrl_lut: purely combinational {ALU_Op, funct} → {code, illegal, multi}, parametrised on FUNCT_W/ALUOP_W. The sequencer FSM and counter live in alu_ctrl_seq.

Test Plan:
- Reset then ALU_Op=00, funct=10110, Out_Ready=1 → Out_Valid on cycle N+1, ALU_Control=0001, Illegal=0; In_Ready=1 throughout.
- ALU_Op=10, funct=00010 (mul), MUL_LAT=3 → Busy for 3 cycles, Out_Valid at N+3, ALU_Control=0101, Multi_Cycle=1; In_Ready=0 in EXEC.
- ALU_Op=10, funct=00011 (div), DIV_LAT=8, Out_Ready held 0 for 4 extra cycles → Out_Valid from N+8 to N+12 with ALU_Control=0110 stable; a second request is accepted in the same cycle Out_Ready rises.
- Back-to-back: In_Valid=1 for ALU_Op=01, then ALU_Op=10/funct=01001, Out_Ready=1 → results 0010, then 1100 on consecutive cycles, no bubble.
- ALU_Op=10, funct=01111 → ALU_Control=1111, Illegal=1, latency 1.
- Flush at N+2 of a div; then async rst asserted mid-HOLD → Out_Valid=0 next cycle after Flush, no result emitted; on rst all outputs 0 immediately.
